// File: rtl/lc4_div_pkg.sv
// Shared definitions for the LC4 sequential divider.
// Holds the state encodings, the default operand width and a helper that
// checks whether a STEPS_PER_CYCLE choice is legal.
package lc4_div_pkg;

   localparam int WIDTH_DEFAULT = 16;

   // State encodings are fixed values so existing tooling can decode them.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Only 1, 2 or 4 restoring steps per clock are supported.
   // The step count must also divide the width, so the counter lands exactly on WIDTH.
   function automatic bit steps_legal(input int width, input int steps);
      return ((steps == 1) || (steps == 2) || (steps == 4)) && ((width % steps) == 0);
   endfunction

endpackage

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step, MSB first.
// The partial remainder is widened to WIDTH+1 bits before the compare. This
// keeps the bit shifted out of rem when the divisor exceeds 2^(WIDTH-1).
module lc4_div_step
   import lc4_div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] dvd,
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quot,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] dvd_next,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quot_next
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] r_sub;
   logic           q_bit;
   // The result is always below the divisor, so the top bits are never needed.
   logic           unused_msb;

   // Shift in the next dividend bit, then subtract if the divisor fits.
   always_comb begin
      // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
      r_shift   = {rem, dvd[WIDTH-1]};
      r_sub     = r_shift - {1'b0, divisor};
      q_bit     = (r_shift >= {1'b0, divisor});
      rem_next  = q_bit ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
      dvd_next  = {dvd[WIDTH-2:0], 1'b0};
      quot_next = {quot[WIDTH-2:0], q_bit};
   end

   assign unused_msb = r_sub[WIDTH] ^ r_shift[WIDTH];

endmodule

// File: rtl/lc4_divider_seq.sv
// Multi-cycle unsigned LC4 DIV/MOD sequencer.
// Accepts one request in IDLE and runs STEPS_PER_CYCLE restoring steps per
// clock in RUN. It then holds quotient, remainder and tag in DONE until the
// consumer takes them. A flush returns the sequencer to IDLE from any state.
module lc4_divider_seq
   import lc4_div_pkg::*;
#(
   parameter int WIDTH           = WIDTH_DEFAULT,
   parameter int STEPS_PER_CYCLE = 1,
   parameter int TAG_W           = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_flush,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_busy
);

   localparam int             CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] STEP_INC = CNT_W'(STEPS_PER_CYCLE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

   if (!steps_legal(WIDTH, STEPS_PER_CYCLE)) begin : g_bad_steps
      $error("lc4_divider_seq: STEPS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
   end

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quot_q;
   logic [TAG_W-1:0] tag_q;

   // Step chain: index 0 is the registered value, index STEPS_PER_CYCLE is the next value.
   logic [WIDTH-1:0] dvd_c  [STEPS_PER_CYCLE+1];
   logic [WIDTH-1:0] rem_c  [STEPS_PER_CYCLE+1];
   logic [WIDTH-1:0] quot_c [STEPS_PER_CYCLE+1];

   assign dvd_c[0]  = dvd_q;
   assign rem_c[0]  = rem_q;
   assign quot_c[0] = quot_q;

   for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
      lc4_div_step #(.WIDTH(WIDTH)) u_step (
         .dvd       (dvd_c[i]),
         .rem       (rem_c[i]),
         .quot      (quot_c[i]),
         .divisor   (divisor_q),
         .dvd_next  (dvd_c[i+1]),
         .rem_next  (rem_c[i+1]),
         .quot_next (quot_c[i+1])
      );
   end

   // FSM, step counter and operand/result registers.
   // A zero divisor spends one RUN cycle without stepping. The response
   // then appears one edge after acceptance, with quotient and remainder held at 0.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         // NOTE: this block has no memory arrays, so clearing every register on reset is cheap and gives known outputs.
         state     <= ST_IDLE;
         count     <= '0;
         dvd_q     <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         tag_q     <= '0;
      end else if (i_flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  dvd_q     <= i_dividend;
                  divisor_q <= i_divisor;
                  tag_q     <= i_tag;
                  rem_q     <= '0;
                  quot_q    <= '0;
                  count     <= '0;
                  state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (divisor_q == '0) begin
                  state <= ST_DONE;
               end else begin
                  dvd_q  <= dvd_c[STEPS_PER_CYCLE];
                  rem_q  <= rem_c[STEPS_PER_CYCLE];
                  quot_q <= quot_c[STEPS_PER_CYCLE];
                  count  <= count + STEP_INC;
                  if ((count + STEP_INC) == LAST_CNT) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (i_rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_req_ready = (state == ST_IDLE);
   assign o_rsp_valid = (state == ST_DONE);
   assign o_busy      = (state == ST_RUN) || (state == ST_DONE);
   assign o_quotient  = quot_q;
   assign o_remainder = rem_q;
   assign o_tag       = tag_q;

endmodule
